// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: data-memory access-width encodings and default depth.
package mips_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned DM_TYPE_W      = 4;
  localparam int unsigned DM_DEPTH_WORDS = 3072;

  localparam logic [DM_TYPE_W-1:0] DM_WORD = 4'b0001;
  localparam logic [DM_TYPE_W-1:0] DM_HALF = 4'b0010;
  localparam logic [DM_TYPE_W-1:0] DM_BYTE = 4'b0100;

  // True when dm_type is exactly one of the supported widths.
  function automatic logic dm_type_legal(input logic [DM_TYPE_W-1:0] t);
    return (t == DM_WORD) || (t == DM_HALF) || (t == DM_BYTE);
  endfunction

  // True when the byte offset satisfies the natural alignment of the width.
  function automatic logic dm_aligned(input logic [DM_TYPE_W-1:0] t, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (t)
      DM_WORD: ok = (off == 2'b00);
      DM_HALF: ok = (off[0] == 1'b0);
      DM_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Store lane merger: folds narrow store data into the old word and reports the byte enables.
module dm_lane
  import mips_pkg::*;
(
  input  logic [1:0]           offset,
  input  logic [DM_TYPE_W-1:0] dm_type,
  input  logic [XLEN-1:0]      old_word,
  input  logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      merged_c,
  output logic [3:0]           be_c
);

  logic [XLEN-1:0] wdata_rep;

  // Replicate store data across all lanes so each enabled lane picks its own copy.
  always_comb begin
    be_c      = 4'b0000;
    wdata_rep = '0;
    case (dm_type)
      DM_WORD: begin
        be_c      = 4'b1111;
        wdata_rep = wdata;
      end
      DM_HALF: begin
        be_c      = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      DM_BYTE: begin
        be_c      = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      default: begin
        be_c      = 4'b0000;
        wdata_rep = '0;
      end
    endcase
  end

  always_comb begin
    merged_c = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be_c[i]) merged_c[i*8 +: 8] = wdata_rep[i*8 +: 8];
    end
  end

endmodule

// File: rtl/dm_unit.sv
// Data-memory responder: combinational sign-extending loads, lane-merged stores, store counter.
// Optional store trace enabled by defining DM_TRACE_EN.
module dm_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [DM_TYPE_W-1:0] dm_type,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      rdata,
  output logic                 addr_err,
  output logic [XLEN-1:0]      wr_cnt
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [31:0]      index;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       offset;
  logic             in_range;
  logic             legal;
  logic             commit;
  logic [XLEN-1:0]  old_word;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  merged;
  logic [3:0]       be;

  // Address decode and legality; an address below ADDR_BASE wraps high and fails the range test.
  always_comb begin
    index    = (addr - ADDR_BASE) >> 2;
    word_idx = index[IDX_W-1:0];
    offset   = addr[1:0];
    in_range = (index < DEPTH_L);
    legal    = dm_type_legal(dm_type) && dm_aligned(dm_type, offset) && in_range;
    old_word = in_range ? mem[word_idx] : '0;
    addr_err = (we || (dm_type != '0)) && !legal;
  end

  // Load extractor: pre-edge contents, so a same-cycle store is not visible yet.
  always_comb begin
    rdata   = '0;
    shifted = old_word >> {offset, 3'b000};
    if (legal) begin
      case (dm_type)
        DM_WORD: rdata = old_word;
        DM_HALF: rdata = offset[1] ? {{16{old_word[31]}}, old_word[31:16]}
                                   : {{16{old_word[15]}}, old_word[15:0]};
        DM_BYTE: rdata = {{24{shifted[7]}}, shifted[7:0]};
        default: rdata = '0;
      endcase
    end
  end

  dm_lane u_lane (
    .offset   (offset),
    .dm_type  (dm_type),
    .old_word (old_word),
    .wdata    (wdata),
    .merged_c (merged),
    .be_c     (be)
  );

  assign commit = we && legal && (be != 4'b0000);

  // Reset clears the whole array and wins over a simultaneous store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] <= '0;
      wr_cnt <= '0;
    end else if (commit) begin
      mem[word_idx] <= merged;
      wr_cnt        <= wr_cnt + 32'd1;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && commit) begin
      $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule
